// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: data width, default
// frame/gap timing, FSM state encoding and the tick-counter width helper.
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int UART_FRAME_TICKS = 10;
    localparam int UART_GAP_TICKS   = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_t;

    // Bits needed for a counter that must hold values up to max(a, b).
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Bus between the UART transmit scheduler and its surroundings: the requester
// handshake plus the control/data lines toward uart_tx and uart_baud_rate.
// The scheduler uses the slave modport; the environment uses master.
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4
);
    import uart_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*UART_DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           baud_tick;
    logic                           baud_en;
    logic                           tx_en;
    logic [UART_DATA_W-1:0]         tx_data;
    logic [ID_W-1:0]                grant_id;
    logic                           busy;

    modport master (
        output req_valid, req_data, baud_tick,
        input  req_ready, baud_en, tx_en, tx_data, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, baud_tick,
        output req_ready, baud_en, tx_en, tx_data, grant_id, busy
    );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational requester arbiter for the UART transmit scheduler.
// With UART_TX_SCHED_RR_EN defined the search starts at i_ptr and wraps;
// otherwise the lowest-index requester wins and no pointer input exists.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
`ifdef UART_TX_SCHED_RR_EN
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
`endif
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_idx
);

    localparam int ID_W = $clog2(NUM_REQ);

    // Walk the search order from last to first so the final hit is the winner.
    always_comb begin
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef UART_TX_SCHED_RR_EN
            j = int'(i_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
`else
            j = k;
`endif
            if (i_req[j]) begin
                o_grant    = '0;
                o_grant[j] = 1'b1;
                o_idx      = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Scheduler sharing one UART transmit path among NUM_REQ byte requesters.
// Accepts one byte in IDLE, latches it onto tx_data, raises tx_en and the
// baud enable, and counts baud ticks to end the frame and the idle gap.
// Optional feature: define UART_TX_SCHED_RR_EN for round-robin arbitration;
// without it the lowest-index requester always wins.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int FRAME_TICKS = UART_FRAME_TICKS,
    parameter int GAP_TICKS   = UART_GAP_TICKS
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_sched_if.slave   io_bus
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(FRAME_TICKS, GAP_TICKS);

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    sched_state_t           r_state;
    sched_state_t           w_state_nxt;
    logic [UART_DATA_W-1:0] r_tx_data;
    logic [UART_DATA_W-1:0] w_tx_data_nxt;
    logic [ID_W-1:0]        r_grant_id;
    logic [ID_W-1:0]        w_grant_id_nxt;
    logic                   r_tx_en;
    logic                   w_tx_en_nxt;
    logic                   r_baud_en;
    logic                   w_baud_en_nxt;
    logic                   r_busy;
    logic                   w_busy_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;

    logic [NUM_REQ-1:0]     w_arb_grant;
    logic [ID_W-1:0]        w_arb_idx;
    logic [NUM_REQ-1:0]     w_ready;
    logic                   w_accept;
    logic [UART_DATA_W-1:0] w_sel_byte;

`ifdef UART_TX_SCHED_RR_EN
    logic [ID_W-1:0]        r_rr_ptr;
    logic [ID_W-1:0]        w_rr_ptr_nxt;
`endif

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req   (io_bus.req_valid),
`ifdef UART_TX_SCHED_RR_EN
        .i_ptr   (r_rr_ptr),
`endif
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx)
    );

    // Ready is offered only while idle, so a transfer always starts a frame.
    assign w_ready    = (r_state == ST_IDLE) ? w_arb_grant : '0;
    assign w_accept   = |(io_bus.req_valid & w_ready);
    assign w_sel_byte = io_bus.req_data[int'(w_arb_idx) * UART_DATA_W +: UART_DATA_W];

    assign io_bus.req_ready = w_ready;
    assign io_bus.tx_data   = r_tx_data;
    assign io_bus.grant_id  = r_grant_id;
    assign io_bus.tx_en     = r_tx_en;
    assign io_bus.baud_en   = r_baud_en;
    assign io_bus.busy      = r_busy;

    // Next-state and registered-output decisions for the frame sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_tx_data_nxt  = r_tx_data;
        w_grant_id_nxt = r_grant_id;
        w_tx_en_nxt    = r_tx_en;
        w_baud_en_nxt  = r_baud_en;
        w_busy_nxt     = r_busy;
        w_cnt_nxt      = r_cnt;
`ifdef UART_TX_SCHED_RR_EN
        w_rr_ptr_nxt   = r_rr_ptr;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_tx_data_nxt  = w_sel_byte;
                    w_grant_id_nxt = w_arb_idx;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = ST_LOAD;
`ifdef UART_TX_SCHED_RR_EN
                    w_rr_ptr_nxt   = (w_arb_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                                        : w_arb_idx + ID_W'(1);
`endif
                end
            end
            ST_LOAD: begin
                // tx_data has been stable for this cycle before tx_en rises.
                w_tx_en_nxt   = 1'b1;
                w_baud_en_nxt = 1'b1;
                w_cnt_nxt     = '0;
                w_state_nxt   = ST_SEND;
            end
            ST_SEND: begin
                if (io_bus.baud_tick) begin
                    if (r_cnt == FRAME_LAST) begin
                        w_tx_en_nxt = 1'b0;
                        w_cnt_nxt   = '0;
                        if (GAP_TICKS > 0) begin
                            w_state_nxt = ST_GAP;
                        end else begin
                            w_baud_en_nxt = 1'b0;
                            w_busy_nxt    = 1'b0;
                            w_state_nxt   = ST_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (io_bus.baud_tick) begin
                    if (r_cnt == GAP_LAST) begin
                        w_baud_en_nxt = 1'b0;
                        w_busy_nxt    = 1'b0;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, frame outputs and tick counter; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tx_data  <= '0;
            r_grant_id <= '0;
            r_tx_en    <= 1'b0;
            r_baud_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_tx_en    <= w_tx_en_nxt;
            r_baud_en  <= w_baud_en_nxt;
            r_busy     <= w_busy_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

`ifdef UART_TX_SCHED_RR_EN
    // Round-robin pointer: next search starts just after the last winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a behavioural baud generator stands
// in for uart_baud_rate, and a frame-level reference model predicts winners,
// latched bytes and tick counts for randomized requests.
`timescale 1ns/1ps
module tb_uart_tx_sched;
    import uart_pkg::*;

    localparam int N     = 4;
    localparam int FT    = 10;
    localparam int GT    = 1;
    localparam int DIV   = 130;
    localparam int BOUND = 4 * FT * DIV;

    logic clk = 1'b0;
    logic rst;
    always #25 clk = ~clk;

    logic [N-1:0]   tb_valid = '0;
    logic [N*8-1:0] tb_data  = '0;
    logic [N-1:0]   b_valid  = '0;
    logic [N*8-1:0] b_data   = '0;
    logic           a_stray  = 1'b0;

    uart_tx_sched_if #(.NUM_REQ(N)) a_if ();
    uart_tx_sched_if #(.NUM_REQ(N)) b_if ();

    assign a_if.req_valid = tb_valid;
    assign a_if.req_data  = tb_data;
    assign b_if.req_valid = b_valid;
    assign b_if.req_data  = b_data;

    uart_tx_sched #(.NUM_REQ(N), .FRAME_TICKS(FT), .GAP_TICKS(GT)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (a_if.slave)
    );

    uart_tx_sched #(.NUM_REQ(N), .FRAME_TICKS(FT), .GAP_TICKS(0)) dut_g0 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (b_if.slave)
    );

    // Baud generators: tick every DIV clocks while enabled.
    int   a_div = 0;
    int   b_div = 0;
    logic a_gen = 1'b0;
    logic b_gen = 1'b0;
    always @(posedge clk) begin
        if (!a_if.baud_en) begin
            a_div <= 0; a_gen <= 1'b0;
        end else if (a_div == DIV - 1) begin
            a_div <= 0; a_gen <= 1'b1;
        end else begin
            a_div <= a_div + 1; a_gen <= 1'b0;
        end
        if (!b_if.baud_en) begin
            b_div <= 0; b_gen <= 1'b0;
        end else if (b_div == DIV - 1) begin
            b_div <= 0; b_gen <= 1'b1;
        end else begin
            b_div <= b_div + 1; b_gen <= 1'b0;
        end
    end
    assign a_if.baud_tick = a_gen | a_stray;
    assign b_if.baud_tick = b_gen;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference arbitration: round-robin from m_ptr, or lowest index.
    int m_ptr = 0;
    function automatic int model_winner(input logic [N-1:0] v);
`ifdef UART_TX_SCHED_RR_EN
        for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
`else
        for (int k = 0; k < N; k++) if (v[k]) return k;
`endif
        return -1;
    endfunction

    // One complete frame on DUT a, entered while idle; returns at the first IDLE cycle.
    task automatic run_frame(input string tag, output int winner);
        int w, wt, n, cyc;
        logic [7:0] byte_exp;
        bit stable;
        w  = model_winner(tb_valid);
        wt = 0;
        while (((a_if.req_valid & a_if.req_ready) == '0) && wt < BOUND) begin
            @(negedge clk);
            wt++;
        end
        check_eq({tag, "_accept_in_time"}, 32'(wt < BOUND), 1);
        winner = w;
        if (wt >= BOUND || w < 0) return;
        check_eq({tag, "_no_bubble"}, wt, 0);
        check_eq({tag, "_ready"}, 32'(a_if.req_ready), 32'(1 << w));
        byte_exp = tb_data[8*w +: 8];
        m_ptr = (w + 1) % N;
        @(negedge clk);
        check_eq({tag, "_tx_data"}, 32'(a_if.tx_data), 32'(byte_exp));
        check_eq({tag, "_grant_id"}, 32'(a_if.grant_id), w);
        check_eq({tag, "_load"}, 32'({a_if.busy, a_if.tx_en, a_if.baud_en, |a_if.req_ready}), 8);
        @(negedge clk);
        check_eq({tag, "_send"}, 32'({a_if.tx_en, a_if.baud_en}), 3);
        n = 0; cyc = 0; stable = 1'b1;
        while (a_if.tx_en === 1'b1 && cyc < BOUND) begin
            if (a_if.baud_tick) n++;
            if (a_if.tx_data !== byte_exp) stable = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_frame_ticks"}, n, FT);
        check_eq({tag, "_data_stable"}, 32'(stable), 1);
        check_eq({tag, "_gap_entry"}, 32'({a_if.baud_en, a_if.busy}), 3);
        n = 0;
        while (a_if.baud_en === 1'b1 && cyc < BOUND) begin
            if (a_if.baud_tick) n++;
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_gap_ticks"}, n, GT);
        check_eq({tag, "_idle"}, 32'({a_if.busy, a_if.tx_en}), 0);
    endtask

    initial begin
        int w, wt, n, idle_bad;
        logic [7:0] wd_byte;
        int exp_seq[5];
`ifdef UART_TX_SCHED_RR_EN
        exp_seq = '{0, 1, 2, 3, 0};
`else
        exp_seq = '{0, 0, 0, 0, 0};
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("por_ctrl", 32'({a_if.tx_en, a_if.baud_en, a_if.busy, a_if.req_ready}), 0);
        check_eq("por_data", 32'(a_if.tx_data), 0);
        check_eq("por_grant", 32'(a_if.grant_id), 0);
        rst = 1'b0;
        m_ptr = 0;
        @(negedge clk);

        // All requesters valid continuously: five frames back to back.
        tb_valid = 4'hF;
        tb_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        #1;
        for (int i = 0; i < 5; i++) begin
            run_frame($sformatf("all%0d", i), w);
            check_eq($sformatf("all%0d_seq", i), w, exp_seq[i]);
        end
        tb_valid = '0;

        // Single request from requester 2 with byte A5.
        tb_data = $urandom;
        tb_data[23:16] = 8'hA5;
        tb_valid = 4'b0100;
        #1;
        run_frame("single", w);
        check_eq("single_id", w, 2);
        tb_valid = '0;

        // Requester 2 pulses valid for one cycle while busy: never accepted.
        tb_data  = $urandom;
        wd_byte  = tb_data[7:0];
        tb_valid = 4'b0001;
        #1;
        fork
            run_frame("wd", w);
            begin
                @(negedge clk);
                tb_valid = '0;
                repeat (2 * DIV) @(negedge clk);
                tb_valid = 4'b0100;
                #1 check_eq("wd_pulse_ready", 32'(a_if.req_ready), 0);
                @(negedge clk);
                tb_valid = '0;
            end
        join
        repeat (20) @(negedge clk);
        check_eq("wd_no_accept", 32'({a_if.busy, a_if.tx_en}), 0);
        check_eq("wd_tx_data_hold", 32'(a_if.tx_data), 32'(wd_byte));

        // Stray baud ticks while idle are ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); a_stray = 1'b1;
            @(negedge clk); a_stray = 1'b0;
        end
        @(negedge clk);
        check_eq("stray_ignored", 32'({a_if.baud_en, a_if.tx_en, a_if.busy}), 0);

        // Randomized request patterns against the reference model.
        for (int i = 0; i < 8; i++) begin
            tb_valid = 4'($urandom_range(1, 15));
            tb_data  = $urandom;
            #1;
            run_frame($sformatf("rnd%0d", i), w);
        end
        tb_valid = '0;

        // Reset in the middle of a frame.
        tb_valid = 4'b0001;
        tb_data  = $urandom;
        wt = 0;
        while (a_if.tx_en !== 1'b1 && wt < BOUND) begin @(negedge clk); wt++; end
        tb_valid = '0;
        check_eq("rst_reach_send", 32'(wt < BOUND), 1);
        repeat (3 * DIV) @(negedge clk);
        check_eq("rst_midframe", 32'(a_if.tx_en), 1);
        #5 rst = 1'b1;
        #1;
        check_eq("rst_async_ctrl", 32'({a_if.tx_en, a_if.baud_en, a_if.busy, a_if.req_ready}), 0);
        check_eq("rst_async_data", 32'(a_if.tx_data), 0);
        check_eq("rst_async_grant", 32'(a_if.grant_id), 0);
        #49 rst = 1'b0;
        m_ptr = 0;
        idle_bad = 0;
        repeat (4 * DIV) begin
            @(negedge clk);
            if (a_if.tx_en !== 1'b0 || a_if.busy !== 1'b0) idle_bad++;
        end
        check_eq("rst_no_resend", idle_bad, 0);

        // GAP_TICKS = 0: second LOAD one clock after the final SEND tick.
        @(negedge clk);
        b_data  = $urandom;
        b_valid = 4'b0011;
        wt = 0;
        while (b_if.tx_en !== 1'b1 && wt < BOUND) begin @(negedge clk); wt++; end
        check_eq("g0_start", 32'(wt < BOUND), 1);
        check_eq("g0_first_grant", 32'(b_if.grant_id), 0);
        n = 0; wt = 0;
        while (b_if.tx_en === 1'b1 && wt < BOUND) begin
            if (b_if.baud_tick) n++;
            @(negedge clk);
            wt++;
        end
        check_eq("g0_frame_ticks", n, FT);
        check_eq("g0_idle", 32'({b_if.baud_en, b_if.busy}), 0);
        check_eq("g0_ready_now", 32'(|b_if.req_ready), 1);
        @(negedge clk);
        check_eq("g0_load", 32'({b_if.baud_en, b_if.busy, b_if.tx_en}), 2);
`ifdef UART_TX_SCHED_RR_EN
        check_eq("g0_second_grant", 32'(b_if.grant_id), 1);
`else
        check_eq("g0_second_grant", 32'(b_if.grant_id), 0);
`endif
        @(negedge clk);
        check_eq("g0_send", 32'({b_if.baud_en, b_if.tx_en}), 3);
        b_valid = '0;
        wt = 0;
        while (b_if.busy !== 1'b0 && wt < BOUND) begin @(negedge clk); wt++; end
        check_eq("g0_done", 32'(wt < BOUND), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
